// File: rtl/parity_add_pipe_pkg.sv
// Shared defaults and parity-mode encoding for the add-and-parity pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package parity_add_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 1;
    localparam int DEF_CNT_W = 16;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_add_pipe_delay_line.sv
// Hold-enabled shift register carrying {valid, parity, sum} to the outputs.
// Latency: DEPTH edges.
// Backpressure: every stage, valid bit included, freezes while hold=1.
module parity_delay_line #(
    parameter int W     = 10,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stg [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else if (!hold) begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/parity_add_pipe.sv
// Registers a word, adds an offset mod 2^WIDTH, reduces to parity, delays the result.
// Latency: DEPTH+2 edges from the capture edge; one word per clock.
// Backpressure: out_valid & ~out_ready stalls the whole pipe and drops in_ready.
module parity_add_pipe
    import parity_add_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] offset,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             data_out,
    output logic [WIDTH-1:0] sum_out,
    output logic [CNT_W-1:0] ones_cnt,
    input  logic             cnt_clr
);

    localparam int LW = WIDTH + 2;

    logic             stall;
    logic             accept;

    logic             v1;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] off1;
    logic             odd1;

    logic [WIDTH-1:0] sum_c;
    logic             par_c;

    logic             v2;
    logic             par2;
    logic [WIDTH-1:0] sum2;

    logic [LW-1:0]    dl_out;

    // in_ready must not look at in_valid, so it is purely the stall term.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1   <= 1'b0;
            d1   <= '0;
            off1 <= '0;
            odd1 <= PAR_EVEN;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                d1   <= data_in;
                off1 <= offset;
                odd1 <= odd_mode;
            end
        end
    end

    // Carry-out dropped on purpose: the sum wraps modulo 2^WIDTH.
    assign sum_c = d1 + off1;
    assign par_c = (^sum_c) ^ (odd1 == PAR_ODD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2   <= 1'b0;
            par2 <= 1'b0;
            sum2 <= '0;
        end else if (!stall) begin
            v2   <= v1;
            par2 <= par_c;
            sum2 <= sum_c;
        end
    end

    parity_delay_line #(
        .W     (LW),
        .DEPTH (DEPTH)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .hold (stall),
        .din  ({v2, par2, sum2}),
        .dout (dl_out)
    );

    assign out_valid = dl_out[LW-1];
    assign data_out  = dl_out[WIDTH];
    assign sum_out   = dl_out[WIDTH-1:0];

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_cnt <= '0;
        end else if (cnt_clr) begin
            ones_cnt <= '0;
        end else if (out_valid && out_ready && data_out && (ones_cnt != '1)) begin
            ones_cnt <= ones_cnt + CNT_W'(1);
        end
    end

endmodule
